speed_level_gen: RTL

Parametrised game-speed generator. It decodes a thermometer-coded switch bank into one of `NUM_LEVELS` speed levels and produces that level's tick and square-wave clock from the system clock, using its own divider. It adds switch debouncing, glitch-free level changes at tick boundaries, and an auto-advance mode that raises the level every `ADV_TICKS` ticks. It sits between the board switch inputs and the game-timing logic, and drives the game's step enable and start-valid signal.

---
 rtl/speed_level_pkg.sv | 32 +++
 rtl/sw_debounce.sv | 38 +++
 rtl/speed_level_gen.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/speed_level_pkg.sv
// rtl/speed_level_pkg.sv - shared types and helpers for the speed level generator
package speed_level_pkg;

    typedef enum logic {IDLE, RUN} state_e;

    typedef struct packed {
        logic       valid;
        logic [7:0] k;
    } dec_t;

    function automatic int unsigned period(input int unsigned lvl,
                                           input int unsigned num_levels,
                                           input int unsigned step_cycles);
        return (num_levels - lvl) * step_cycles;
    endfunction

    // Only a contiguous run of ones from bit 0 (2^(k+1)-1) selects a level.
    function automatic dec_t thermo_decode(input logic [63:0] code,
                                           input int unsigned num_levels);
        dec_t d;
        d = '0;
        for (int k = 0; k < 32; k++) begin
            if ((unsigned'(k) < num_levels) &&
                (code == ((64'd1 << (k + 1)) - 64'd1))) begin
                d.valid = 1'b1;
                d.k     = 8'(k);
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - accepts a switch bank value once it has been steady long enough
module sw_debounce #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] sw_stable
);
    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sw_q;
    logic [WIDTH-1:0] sw_stable_q;
    logic [CW-1:0]    stab_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_q        <= '0;
            stab_cnt_q  <= '0;
            sw_stable_q <= '0;
        end else begin
            sw_q <= sw;
            if (sw != sw_q) begin
                stab_cnt_q <= '0;
            end else if (stab_cnt_q != CNT_MAX) begin
                stab_cnt_q <= stab_cnt_q + CW'(1);
            end
            if (stab_cnt_q == CNT_MAX) begin
                sw_stable_q <= sw_q;
            end
        end
    end

    assign sw_stable = sw_stable_q;

endmodule

// File: rtl/speed_level_gen.sv
// rtl/speed_level_gen.sv - switch-selected game speed tick generator with auto-advance
module speed_level_gen
    import speed_level_pkg::*;
#(
    parameter int NUM_LEVELS    = 7,
    parameter int SW_WIDTH      = 8,
    parameter int STEP_CYCLES   = 20_000_000,
    parameter int STABLE_CYCLES = 1_000_000,
    parameter int ADV_TICKS     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SW_WIDTH-1:0]           sw,
    input  logic                          auto_adv,
    output logic                          tick,
    output logic                          clk_out,
    output logic                          valid_start,
    output logic [$clog2(NUM_LEVELS)-1:0] level,
    output logic                          level_up
);
    localparam int LW    = $clog2(NUM_LEVELS);
    localparam int CNT_W = $clog2(NUM_LEVELS * STEP_CYCLES);
    localparam int TW    = $clog2(ADV_TICKS + 1);

    logic [SW_WIDTH-1:0] sw_stable;

    sw_debounce #(
        .WIDTH        (SW_WIDTH),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .sw       (sw),
        .sw_stable(sw_stable)
    );

    // Registered decode keeps the decode cone out of the FSM's timing path.
    dec_t          dec_w;
    logic          dec_valid_q;
    logic [LW-1:0] dec_k_q;

    always_comb dec_w = thermo_decode(64'(sw_stable), NUM_LEVELS);

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_valid_q <= 1'b0;
            dec_k_q     <= '0;
        end else begin
            dec_valid_q <= dec_w.valid && (dec_w.k < 8'(NUM_LEVELS));
            dec_k_q     <= LW'(dec_w.k);
        end
    end

    state_e             state_q, state_d;
    logic [LW-1:0]      level_q, level_d, req_last_q, req_last_d;
    logic [CNT_W-1:0]   div_cnt_q, div_cnt_d, last_w;
    logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
    logic               pending_q, pending_d, pend_now;
    logic               tick_q, tick_d, clk_out_q, clk_out_d;
    logic               valid_q, valid_d, level_up_q, level_up_d;

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        req_last_d = req_last_q;
        div_cnt_d  = div_cnt_q;
        tick_cnt_d = tick_cnt_q;
        pending_d  = pending_q;
        clk_out_d  = clk_out_q;
        valid_d    = valid_q;
        tick_d     = 1'b0;
        level_up_d = 1'b0;
        pend_now   = 1'b0;
        last_w     = CNT_W'(period(32'(level_q), NUM_LEVELS, STEP_CYCLES)) - CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (dec_valid_q) begin
                    state_d    = RUN;
                    level_d    = dec_k_q;
                    req_last_d = dec_k_q;
                    div_cnt_d  = '0;
                    tick_cnt_d = '0;
                    pending_d  = 1'b0;
                    clk_out_d  = 1'b0;
                    valid_d    = 1'b1;
                end
            end
            RUN: begin
                if (!dec_valid_q) begin
                    state_d    = IDLE;
                    level_d    = '0;
                    req_last_d = '0;
                    div_cnt_d  = '0;
                    tick_cnt_d = '0;
                    pending_d  = 1'b0;
                    clk_out_d  = 1'b0;
                    valid_d    = 1'b0;
                end else begin
                    pend_now   = pending_q || (dec_k_q != req_last_q);
                    req_last_d = dec_k_q;
                    if (div_cnt_q >= last_w) begin
                        div_cnt_d = '0;
                        tick_d    = 1'b1;
                        clk_out_d = ~clk_out_q;
                        // A switch request at the boundary takes precedence over auto-advance.
                        if (pend_now) begin
                            level_d    = dec_k_q;
                            tick_cnt_d = '0;
                            pending_d  = 1'b0;
                        end else if (auto_adv) begin
                            if (tick_cnt_q >= TW'(ADV_TICKS - 1)) begin
                                if (level_q < LW'(NUM_LEVELS - 1)) begin
                                    level_d    = level_q + LW'(1);
                                    level_up_d = 1'b1;
                                    tick_cnt_d = '0;
                                end else begin
                                    tick_cnt_d = TW'(ADV_TICKS);
                                end
                            end else begin
                                tick_cnt_d = tick_cnt_q + TW'(1);
                            end
                        end else begin
                            tick_cnt_d = '0;
                        end
                    end else begin
                        div_cnt_d = div_cnt_q + CNT_W'(1);
                        pending_d = pend_now;
                        if (!auto_adv) begin
                            tick_cnt_d = '0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            level_q    <= '0;
            req_last_q <= '0;
            div_cnt_q  <= '0;
            tick_cnt_q <= '0;
            pending_q  <= 1'b0;
            tick_q     <= 1'b0;
            clk_out_q  <= 1'b0;
            valid_q    <= 1'b0;
            level_up_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            req_last_q <= req_last_d;
            div_cnt_q  <= div_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            pending_q  <= pending_d;
            tick_q     <= tick_d;
            clk_out_q  <= clk_out_d;
            valid_q    <= valid_d;
            level_up_q <= level_up_d;
        end
    end

    assign tick        = tick_q;
    assign clk_out     = clk_out_q;
    assign valid_start = valid_q;
    assign level       = level_q;
    assign level_up    = level_up_q;

endmodule
